sample_sequencer: RTL and testbench

SAMPLE_SEQUENCER -- requirements
Module: sample_sequencer

---
 rtl/sample_sequencer_pkg.sv | 25 ++
 rtl/sample_sequencer_next_chan_pick.sv | 44 ++++
 rtl/sample_sequencer.sv | 234 +++++++++++++++++++++++
 tb/tb_sample_sequencer.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sample_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sample_seq_pkg
// Description : Shared definitions for the oscillator sample sequencer.
//               Holds the FSM state encoding and the sweep mode constants.
// Revision    : 1.0 - initial release
// ============================================================================
package sample_seq_pkg;

   // Sequencer FSM states, explicit 3-bit encoding
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_CLEAR   = 3'd1,
      ST_SETTLE  = 3'd2,
      ST_COUNT   = 3'd3,
      ST_SAMPLE  = 3'd4,
      ST_ADVANCE = 3'd5
   } state_t;

   // Sweep mode values as seen on mode_i
   localparam logic MODE_CONT   = 1'b0;
   localparam logic MODE_SINGLE = 1'b1;

endpackage
`default_nettype wire

// File: rtl/sample_sequencer_next_chan_pick.sv
`default_nettype none
// ============================================================================
// Module      : next_chan_pick
// Description : Combinational channel picker. From a channel mask and the
//               current channel index returns the next set bit above the
//               current index, the lowest set bit, and a wrap flag raised
//               when no set bit exists above the current index.
// Ports       : mask_i     - channel enable mask
//               cur_i      - current channel index
//               next_idx_o - next set bit above cur_i (valid when !wrap_o)
//               low_idx_o  - lowest set bit of mask_i (0 when mask is empty)
//               wrap_o     - no set bit above cur_i
// Revision    : 1.0 - initial release
// ============================================================================
module next_chan_pick #(
   parameter int NUM_OSC = 10,
   parameter int SEL_W   = 5
) (
   input  logic [NUM_OSC-1:0] mask_i,
   input  logic [SEL_W-1:0]   cur_i,
   output logic [SEL_W-1:0]   next_idx_o,
   output logic [SEL_W-1:0]   low_idx_o,
   output logic               wrap_o
);
   import sample_seq_pkg::*;

   // Scan from the top down so the last hit written is the lowest one.
   always_comb begin
      next_idx_o = '0;
      low_idx_o  = '0;
      wrap_o     = 1'b1;
      for (int i = NUM_OSC - 1; i >= 0; i--) begin
         if (mask_i[i]) begin
            low_idx_o = SEL_W'(i);
            if (i > int'(cur_i)) begin
               next_idx_o = SEL_W'(i);
               wrap_o     = 1'b0;
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sample_sequencer
// Description : Sweeps a set of ring oscillators. For each enabled channel:
//               clear the counter, settle, count, then request a sample and
//               wait for the SRAM writer to accept it. Supports single and
//               continuous sweeps, immediate abort and deferred stop.
// Ports       : clk, rstn (async, active-low)
//               start_i, stop_i, mode_i, chan_mask_i, settle_len_i,
//               count_len_i, sample_ack_i           - control inputs
//               test_enable_o, osc_sel_o, count_o,
//               sample_o, resetn_o                  - oscillator/counter side
//               busy_o, done_o, sweep_cnt_o         - status
// Revision    : 1.0 - initial release
// ============================================================================
module sample_sequencer #(
   parameter int NUM_OSC = 10,
   parameter int SEL_W   = 5,
   parameter int WIN_W   = 16
) (
   input  logic               clk,
   input  logic               rstn,
   input  logic               start_i,
   input  logic               stop_i,
   input  logic               mode_i,
   input  logic [NUM_OSC-1:0] chan_mask_i,
   input  logic [WIN_W-1:0]   settle_len_i,
   input  logic [WIN_W-1:0]   count_len_i,
   input  logic               sample_ack_i,
   output logic [NUM_OSC-1:0] test_enable_o,
   output logic [SEL_W-1:0]   osc_sel_o,
   output logic               count_o,
   output logic               sample_o,
   output logic               resetn_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [15:0]        sweep_cnt_o
);
   import sample_seq_pkg::*;

   state_t             state_q;
   logic               mode_q;
   logic [NUM_OSC-1:0] mask_q;
   logic [WIN_W-1:0]   settle_q;
   logic [WIN_W-1:0]   cnt_len_q;
   logic [WIN_W-1:0]   dwell_q;
   logic [SEL_W-1:0]   sel_q;
   logic [SEL_W-1:0]   next_q;
   logic               wrap_q;
   logic               stop_pend_q;
   logic [NUM_OSC-1:0] te_q;
   logic               count_q;
   logic               sample_q;
   logic               resetn_q;
   logic               busy_q;
   logic               done_q;
   logic [15:0]        sweep_q;

   logic [NUM_OSC-1:0] w_pick_mask;
   logic [SEL_W-1:0]   w_next;
   logic [SEL_W-1:0]   w_low;
   logic               w_wrap;
   logic [NUM_OSC-1:0] w_onehot;
   logic [WIN_W-1:0]   w_settle_ld;
   logic [WIN_W-1:0]   w_count_ld;

   // One picker serves both needs: during SAMPLE it looks at the latched
   // mask and its next/wrap result is captured for ADVANCE; elsewhere it
   // looks at the live mask so IDLE and a continuous wrap get the lowest bit
   // of the mask being latched.
   assign w_pick_mask = (state_q == ST_SAMPLE) ? mask_q : chan_mask_i;

   next_chan_pick #(
      .NUM_OSC (NUM_OSC),
      .SEL_W   (SEL_W)
   ) u_pick (
      .mask_i     (w_pick_mask),
      .cur_i      (sel_q),
      .next_idx_o (w_next),
      .low_idx_o  (w_low),
      .wrap_o     (w_wrap)
   );

   assign w_onehot = NUM_OSC'(1) << sel_q;

   // Dwell counter counts down to zero, so load length-1; zero acts as one.
   assign w_settle_ld = (settle_q == '0)  ? '0 : settle_q - WIN_W'(1);
   assign w_count_ld  = (cnt_len_q == '0) ? '0 : cnt_len_q - WIN_W'(1);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q     <= ST_IDLE;
         mode_q      <= MODE_CONT;
         mask_q      <= '0;
         settle_q    <= '0;
         cnt_len_q   <= '0;
         dwell_q     <= '0;
         sel_q       <= '0;
         next_q      <= '0;
         wrap_q      <= 1'b0;
         stop_pend_q <= 1'b0;
         te_q        <= '0;
         count_q     <= 1'b0;
         sample_q    <= 1'b0;
         resetn_q    <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         sweep_q     <= '0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               resetn_q <= 1'b1;
               if (start_i && !stop_i) begin
                  if (chan_mask_i != '0) begin
                     mode_q    <= mode_i;
                     mask_q    <= chan_mask_i;
                     settle_q  <= settle_len_i;
                     cnt_len_q <= count_len_i;
                     sel_q     <= w_low;
                     resetn_q  <= 1'b0;
                     busy_q    <= 1'b1;
                     state_q   <= ST_CLEAR;
                  end else begin
                     done_q <= 1'b1;
                  end
               end
            end
            ST_CLEAR: begin
               resetn_q <= 1'b1;
               if (stop_i) begin
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else begin
                  te_q    <= w_onehot;
                  dwell_q <= w_settle_ld;
                  state_q <= ST_SETTLE;
               end
            end
            ST_SETTLE: begin
               if (stop_i) begin
                  te_q    <= '0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (dwell_q == '0) begin
                  count_q <= 1'b1;
                  dwell_q <= w_count_ld;
                  state_q <= ST_COUNT;
               end else begin
                  dwell_q <= dwell_q - WIN_W'(1);
               end
            end
            ST_COUNT: begin
               if (stop_i) begin
                  te_q    <= '0;
                  count_q <= 1'b0;
                  busy_q  <= 1'b0;
                  state_q <= ST_IDLE;
               end else if (dwell_q == '0) begin
                  te_q     <= '0;
                  count_q  <= 1'b0;
                  sample_q <= 1'b1;
                  dwell_q  <= '0;
                  state_q  <= ST_SAMPLE;
               end else begin
                  dwell_q <= dwell_q - WIN_W'(1);
               end
            end
            ST_SAMPLE: begin
               next_q <= w_next;
               wrap_q <= w_wrap;
               if (stop_i) begin
                  stop_pend_q <= 1'b1;
               end
               if (sample_ack_i) begin
                  sample_q <= 1'b0;
                  state_q  <= ST_ADVANCE;
               end
            end
            ST_ADVANCE: begin
               if (stop_pend_q || stop_i) begin
                  stop_pend_q <= 1'b0;
                  done_q      <= 1'b1;
                  busy_q      <= 1'b0;
                  state_q     <= ST_IDLE;
               end else if (!wrap_q) begin
                  sel_q    <= next_q;
                  resetn_q <= 1'b0;
                  state_q  <= ST_CLEAR;
               end else begin
                  sweep_q <= sweep_q + 16'd1;
                  if (mode_q == MODE_SINGLE) begin
                     done_q  <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= ST_IDLE;
                  end else begin
                     mask_q    <= chan_mask_i;
                     settle_q  <= settle_len_i;
                     cnt_len_q <= count_len_i;
                     if (chan_mask_i == '0) begin
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                     end else begin
                        sel_q    <= w_low;
                        resetn_q <= 1'b0;
                        state_q  <= ST_CLEAR;
                     end
                  end
               end
            end
            default: begin
               te_q     <= '0;
               count_q  <= 1'b0;
               sample_q <= 1'b0;
               resetn_q <= 1'b1;
               busy_q   <= 1'b0;
               state_q  <= ST_IDLE;
            end
         endcase
      end
   end

   assign test_enable_o = te_q;
   assign osc_sel_o     = sel_q;
   assign count_o       = count_q;
   assign sample_o      = sample_q;
   assign resetn_o      = resetn_q;
   assign busy_o        = busy_q;
   assign done_o        = done_q;
   assign sweep_cnt_o   = sweep_q;

endmodule
`default_nettype wire

// File: tb/tb_sample_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_sequencer
// Description : Self-checking bench for sample_sequencer. A trace model
//               expands each scenario into the per-cycle input stimulus and
//               the expected outputs; a single runner applies and compares
//               them cycle by cycle. Literal expectations pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_sequencer;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        start_i = 1'b0;
   logic        stop_i = 1'b0;
   logic        mode_i = 1'b0;
   logic [9:0]  chan_mask_i = '0;
   logic [15:0] settle_len_i = '0;
   logic [15:0] count_len_i = '0;
   logic        sample_ack_i = 1'b0;
   logic [9:0]  test_enable_o;
   logic [4:0]  osc_sel_o;
   logic        count_o;
   logic        sample_o;
   logic        resetn_o;
   logic        busy_o;
   logic        done_o;
   logic [15:0] sweep_cnt_o;

   always #5 clk = ~clk;

   sample_sequencer #(
      .NUM_OSC (10),
      .SEL_W   (5),
      .WIN_W   (16)
   ) dut (
      .clk           (clk),
      .rstn          (rstn),
      .start_i       (start_i),
      .stop_i        (stop_i),
      .mode_i        (mode_i),
      .chan_mask_i   (chan_mask_i),
      .settle_len_i  (settle_len_i),
      .count_len_i   (count_len_i),
      .sample_ack_i  (sample_ack_i),
      .test_enable_o (test_enable_o),
      .osc_sel_o     (osc_sel_o),
      .count_o       (count_o),
      .sample_o      (sample_o),
      .resetn_o      (resetn_o),
      .busy_o        (busy_o),
      .done_o        (done_o),
      .sweep_cnt_o   (sweep_cnt_o)
   );

   // One cycle of the trace: inputs to drive and outputs to expect
   typedef struct {
      logic        start, stop, ack;
      logic [9:0]  mask;
      logic [9:0]  te;
      logic [4:0]  sel;
      logic        cnt, smp, rn, busy, done;
      logic [15:0] sweep;
   } ent_t;

   ent_t  q[$];
   int    checks = 0;
   int    errors = 0;
   string scen = "";

   // model state
   int m_sel = 0;
   int m_sweep = 0;

   // observations of the DUT during a run
   int seen_sel[$];
   int n_cnt, n_en, n_smp, n_done, n_busy;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s/%s: got %0d expected %0d", scen, name, got, exp);
      end
   endtask

   task automatic push(input logic st, input logic sp, input logic ak, input logic [9:0] mk,
                       input logic [9:0] te, input int sel, input logic cnt, input logic smp,
                       input logic rn, input logic bsy, input logic dn);
      ent_t e;
      e.start = st; e.stop = sp; e.ack = ak; e.mask = mk;
      e.te = te; e.sel = sel[4:0]; e.cnt = cnt; e.smp = smp;
      e.rn = rn; e.busy = bsy; e.done = dn; e.sweep = m_sweep[15:0];
      q.push_back(e);
   endtask

   task automatic p_idle(input logic dn, input logic st, input logic sp, input logic [9:0] mk);
      push(st, sp, 1'b0, mk, 10'h000, m_sel, 1'b0, 1'b0, 1'b1, 1'b0, dn);
   endtask

   // One channel visit: CLEAR, max(S,1) settle, max(C,1) count, w sample, ADVANCE.
   // stop_c >= 0 aborts on that count cycle (trace ends there).
   // stop_s >= 0 raises stop on that sample cycle.
   task automatic p_channel(input int ch, input int w, input int stop_c, input int stop_s,
                            input logic [9:0] mk, input logic [9:0] adv_mk);
      logic [9:0] oh;
      int s_eff, c_eff;
      oh = '0;
      oh[ch] = 1'b1;
      s_eff = (settle_len_i == 0) ? 1 : int'(settle_len_i);
      c_eff = (count_len_i == 0) ? 1 : int'(count_len_i);
      m_sel = ch;
      push(1'b0, 1'b0, 1'b0, mk, 10'h000, ch, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < s_eff; i++)
         push(1'b0, 1'b0, 1'b0, mk, oh, ch, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      for (int i = 0; i < c_eff; i++) begin
         push(1'b0, (i == stop_c), 1'b0, mk, oh, ch, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
         if (i == stop_c) return;
      end
      for (int i = 0; i < w; i++)
         push(1'b0, (i == stop_s), (i == w - 1), mk, 10'h000, ch, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
      push(1'b0, 1'b0, 1'b0, adv_mk, 10'h000, ch, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
   endtask

   task automatic p_sweep(input logic [9:0] mk);
      for (int ch = 0; ch < 10; ch++)
         if (mk[ch]) p_channel(ch, 1, -1, -1, mk, mk);
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      start_i = 1'b0; stop_i = 1'b0; sample_ack_i = 1'b0; chan_mask_i = '0;
      repeat (2) @(posedge clk);
      #3 rstn = 1'b1;
      m_sel = 0; m_sweep = 0;
      seen_sel.delete();
      n_cnt = 0; n_en = 0; n_smp = 0; n_done = 0; n_busy = 0;
   endtask

   // The compare process: applies the trace and checks every cycle.
   task automatic run_queue();
      ent_t e;
      int   cyc;
      logic [36:0] got, exp;
      cyc = 0;
      while (q.size() > 0) begin
         e = q.pop_front();
         @(posedge clk);
         #1;
         got = {test_enable_o, osc_sel_o, count_o, sample_o, resetn_o, busy_o, done_o, sweep_cnt_o};
         exp = {e.te, e.sel, e.cnt, e.smp, e.rn, e.busy, e.done, e.sweep};
         checks++;
         if (got !== exp) begin
            errors++;
            $display("FAIL %s/trace cyc %0d: got te=%h sel=%0d cnt=%b smp=%b rn=%b busy=%b done=%b sweep=%0d expected te=%h sel=%0d cnt=%b smp=%b rn=%b busy=%b done=%b sweep=%0d",
                     scen, cyc, test_enable_o, osc_sel_o, count_o, sample_o, resetn_o, busy_o,
                     done_o, sweep_cnt_o, e.te, e.sel, e.cnt, e.smp, e.rn, e.busy, e.done, e.sweep);
         end
         if (resetn_o === 1'b0) seen_sel.push_back(int'(osc_sel_o));
         if (count_o === 1'b1) n_cnt++;
         if (test_enable_o != '0 && count_o === 1'b0) n_en++;
         if (sample_o === 1'b1) n_smp++;
         if (done_o === 1'b1) n_done++;
         if (busy_o === 1'b1) n_busy++;
         start_i = e.start; stop_i = e.stop; sample_ack_i = e.ack; chan_mask_i = e.mask;
         cyc++;
      end
      start_i = 1'b0; stop_i = 1'b0; sample_ack_i = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int exp_seq[$];

      // ---- single sweep, all channels, S=4 C=8, ack after one cycle ----
      scen = "single";
      do_reset();
      #1;
      chk("rst_resetn", int'(resetn_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      mode_i = 1'b1; settle_len_i = 16'd4; count_len_i = 16'd8;
      p_idle(1'b0, 1'b1, 1'b0, 10'h3FF);
      p_sweep(10'h3FF);
      m_sweep++;
      p_idle(1'b1, 1'b0, 1'b0, 10'h3FF);
      p_idle(1'b0, 1'b0, 1'b0, 10'h3FF);
      p_idle(1'b0, 1'b0, 1'b0, 10'h3FF);
      chk("model_len", q.size(), 154);
      run_queue();
      exp_seq = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9};
      chk("sel_len", seen_sel.size(), 10);
      for (int i = 0; i < 10 && i < seen_sel.size(); i++) chk("sel_seq", seen_sel[i], exp_seq[i]);
      chk("count_cycles", n_cnt, 80);
      chk("enable_only_cycles", n_en, 40);
      chk("done_pulses", n_done, 1);
      chk("sweep_cnt", int'(sweep_cnt_o), 1);

      // ---- continuous, mask 0x205, three sweeps then stop in CLEAR ----
      scen = "cont";
      do_reset();
      mode_i = 1'b0; settle_len_i = 16'd2; count_len_i = 16'd3;
      p_idle(1'b0, 1'b1, 1'b0, 10'h205);
      for (int s = 0; s < 3; s++) begin
         p_sweep(10'h205);
         m_sweep++;
      end
      m_sel = 0;
      push(1'b0, 1'b1, 1'b0, 10'h205, 10'h000, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      p_idle(1'b0, 1'b0, 1'b0, 10'h205);
      p_idle(1'b0, 1'b0, 1'b0, 10'h205);
      run_queue();
      exp_seq = '{0, 2, 9, 0, 2, 9, 0, 2, 9, 0};
      chk("sel_len", seen_sel.size(), 10);
      for (int i = 0; i < 10 && i < seen_sel.size(); i++) chk("sel_seq", seen_sel[i], exp_seq[i]);
      chk("done_pulses", n_done, 0);
      chk("sweep_cnt", int'(sweep_cnt_o), 3);

      // ---- stop in COUNT of channel 2 ----
      scen = "stop_count";
      do_reset();
      mode_i = 1'b1; settle_len_i = 16'd2; count_len_i = 16'd5;
      p_idle(1'b0, 1'b1, 1'b0, 10'h3FF);
      p_channel(0, 1, -1, -1, 10'h3FF, 10'h3FF);
      p_channel(1, 1, -1, -1, 10'h3FF, 10'h3FF);
      p_channel(2, 1, 2, -1, 10'h3FF, 10'h3FF);
      for (int i = 0; i < 3; i++) p_idle(1'b0, 1'b0, 1'b0, 10'h3FF);
      run_queue();
      chk("sample_cycles", n_smp, 2);
      chk("count_cycles", n_cnt, 13);
      chk("done_pulses", n_done, 0);
      chk("sweep_cnt", int'(sweep_cnt_o), 0);

      // ---- ack delayed 20 cycles, stop raised during SAMPLE ----
      scen = "stop_sample";
      do_reset();
      mode_i = 1'b1; settle_len_i = 16'd1; count_len_i = 16'd1;
      p_idle(1'b0, 1'b1, 1'b0, 10'h3FF);
      p_channel(0, 20, -1, 3, 10'h3FF, 10'h3FF);
      p_idle(1'b1, 1'b0, 1'b0, 10'h3FF);
      p_idle(1'b0, 1'b0, 1'b0, 10'h3FF);
      p_idle(1'b0, 1'b0, 1'b0, 10'h3FF);
      run_queue();
      chk("sample_cycles", n_smp, 20);
      chk("done_pulses", n_done, 1);
      chk("channels_visited", seen_sel.size(), 1);
      chk("sweep_cnt", int'(sweep_cnt_o), 0);

      // ---- zero lengths, empty-mask start, start+stop together ----
      scen = "zero_len";
      do_reset();
      mode_i = 1'b1; settle_len_i = 16'd0; count_len_i = 16'd0;
      p_idle(1'b0, 1'b1, 1'b0, 10'h001);
      p_channel(0, 1, -1, -1, 10'h001, 10'h001);
      m_sweep++;
      p_idle(1'b1, 1'b0, 1'b0, 10'h001);
      p_idle(1'b0, 1'b1, 1'b0, 10'h000);
      p_idle(1'b1, 1'b0, 1'b0, 10'h000);
      p_idle(1'b0, 1'b1, 1'b1, 10'h3FF);
      p_idle(1'b0, 1'b0, 1'b0, 10'h3FF);
      p_idle(1'b0, 1'b0, 1'b0, 10'h3FF);
      run_queue();
      chk("count_cycles", n_cnt, 1);
      chk("enable_only_cycles", n_en, 1);
      chk("done_pulses", n_done, 2);
      chk("busy_cycles", n_busy, 5);

      // ---- continuous, mask re-latched as zero at the wrap ----
      scen = "relatch_zero";
      do_reset();
      mode_i = 1'b0; settle_len_i = 16'd1; count_len_i = 16'd1;
      p_idle(1'b0, 1'b1, 1'b0, 10'h003);
      p_channel(0, 1, -1, -1, 10'h003, 10'h003);
      p_channel(1, 1, -1, -1, 10'h003, 10'h000);
      m_sweep++;
      p_idle(1'b1, 1'b0, 1'b0, 10'h000);
      p_idle(1'b0, 1'b0, 1'b0, 10'h000);
      run_queue();
      chk("done_pulses", n_done, 1);
      chk("sweep_cnt", int'(sweep_cnt_o), 1);

      // ---- asynchronous reset mid-SETTLE ----
      scen = "reset_mid";
      do_reset();
      mode_i = 1'b1; settle_len_i = 16'd6; count_len_i = 16'd2;
      p_idle(1'b0, 1'b1, 1'b0, 10'h3FF);
      m_sel = 0;
      push(1'b0, 1'b0, 1'b0, 10'h3FF, 10'h000, 0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      push(1'b0, 1'b0, 1'b0, 10'h3FF, 10'h001, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      push(1'b0, 1'b0, 1'b0, 10'h3FF, 10'h001, 0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
      run_queue();
      #3 rstn = 1'b0;
      #1;
      chk("async_te", int'(test_enable_o), 0);
      chk("async_busy", int'(busy_o), 0);
      chk("async_resetn", int'(resetn_o), 0);
      chk("async_count", int'(count_o), 0);
      chk("async_sample", int'(sample_o), 0);
      chk("async_done", int'(done_o), 0);
      chk("async_sel", int'(osc_sel_o), 0);
      chk("async_sweep", int'(sweep_cnt_o), 0);
      @(posedge clk);
      @(posedge clk);
      #3 rstn = 1'b1;
      @(posedge clk);
      #1;
      chk("release_resetn", int'(resetn_o), 1);
      chk("release_busy", int'(busy_o), 0);
      chk("release_done", int'(done_o), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
